// File: rtl/rvfi_multi_commit_monitor_if.sv
// Multi-lane RVFI commit bundle observed by rvfi_multi_commit_monitor.
// The core side drives it through master; the monitor samples it through slave.
interface rvfi_multi_commit_monitor_if #(
  parameter int unsigned NRET    = 2,
  parameter int unsigned ORDER_W = 64
);

  logic [NRET-1:0]         valid;
  logic [NRET*ORDER_W-1:0] order;
  logic [NRET*32-1:0]      inst;
  logic [NRET*32-1:0]      pc_rdata;
  logic [NRET*32-1:0]      pc_wdata;

  modport master (
    output valid,
    output order,
    output inst,
    output pc_rdata,
    output pc_wdata
  );

  modport slave (
    input valid,
    input order,
    input inst,
    input pc_rdata,
    input pc_wdata
  );

endinterface

// File: rtl/rvfi_multi_commit_monitor.sv
// Multi-retire RVFI protocol monitor: lane contiguity, order, PC chaining,
// idle watchdog, halt detection and start/stop-marker segment counters.
module rvfi_multi_commit_monitor #(
  parameter int unsigned NRET    = 2,
  parameter int unsigned ORDER_W = 64,
  parameter int unsigned CNT_W   = 64,
  parameter int unsigned TIMEOUT = 100000
) (
  input  logic                          clk,
  input  logic                          rst,
  rvfi_multi_commit_monitor_if.slave    rvfi_i,
  output logic                          halt_o,
  output logic                          error_o,
  output logic [2:0]                    err_code_o,
  output logic [1:0]                    seg_state_o,
  output logic                          seg_done_o,
  output logic [CNT_W-1:0]              inst_count_o,
  output logic [CNT_W-1:0]              cycle_count_o
);

  localparam int unsigned NW = $clog2(NRET + 1);
  localparam int unsigned LW = (NRET > 1) ? $clog2(NRET) : 1;
  localparam int unsigned IW = $clog2(TIMEOUT + 1);

  localparam logic [31:0] INST_BEQ_SELF  = 32'h0000_0063;
  localparam logic [31:0] INST_JAL_SELF  = 32'h0000_006f;
  localparam logic [31:0] INST_HALT_MARK = 32'hF000_2013;
  localparam logic [31:0] INST_SEG_START = 32'h0010_2013;
  localparam logic [31:0] INST_SEG_STOP  = 32'h0020_2013;

  localparam logic [2:0] ERR_NONE     = 3'd0;
  localparam logic [2:0] ERR_GAP      = 3'd1;
  localparam logic [2:0] ERR_ORDER    = 3'd2;
  localparam logic [2:0] ERR_PC       = 3'd3;
  localparam logic [2:0] ERR_TIMEOUT  = 3'd4;
  localparam logic [2:0] ERR_POSTHALT = 3'd5;

  typedef enum logic [1:0] {
    SEG_TOTAL = 2'd0,
    SEG_RUN   = 2'd1,
    SEG_DONE  = 2'd2
  } seg_e;

  // Per-lane views of the flattened bus
  logic [ORDER_W-1:0] lane_order [NRET];
  logic [31:0]        lane_inst  [NRET];
  logic [31:0]        lane_pc_r  [NRET];
  logic [31:0]        lane_pc_w  [NRET];
  logic [NRET-1:0]    active;

  for (genvar g = 0; g < NRET; g++) begin : g_lane
    assign lane_order[g] = rvfi_i.order[g*ORDER_W +: ORDER_W];
    assign lane_inst[g]  = rvfi_i.inst[g*32 +: 32];
    assign lane_pc_r[g]  = rvfi_i.pc_rdata[g*32 +: 32];
    assign lane_pc_w[g]  = rvfi_i.pc_wdata[g*32 +: 32];
  end

  assign active = rvfi_i.valid & {NRET{~rst}};

  // State registers
  logic               halt_q,      halt_d;
  logic               error_q,     error_d;
  logic [2:0]         err_code_q,  err_code_d;
  seg_e               seg_q,       seg_d;
  logic               seg_done_q,  seg_done_d;
  logic [CNT_W-1:0]   inst_cnt_q,  inst_cnt_d;
  logic [CNT_W-1:0]   cyc_cnt_q,   cyc_cnt_d;
  logic [ORDER_W-1:0] exp_order_q, exp_order_d;
  logic               have_pc_q,   have_pc_d;
  logic [31:0]        last_pc_q,   last_pc_d;
  logic [IW-1:0]      idle_q,      idle_d;

  // Lane scan results
  logic [NW-1:0] n_act;
  logic          gap_err;
  logic          order_err;
  logic          pc_err;
  logic          halt_hit;
  logic          start_hit;
  logic          stop_hit;
  logic [LW-1:0] stop_lane;
  logic [31:0]   prev_pc;
  logic          prev_ok;
  logic          timeout_err;
  logic          posthalt_err;
  logic          any_err;
  logic [2:0]    new_code;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W-1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

  // Walk lanes in ascending order; the PC chain runs through earlier lanes first
  always_comb begin
    n_act     = '0;
    gap_err   = 1'b0;
    order_err = 1'b0;
    pc_err    = 1'b0;
    halt_hit  = 1'b0;
    start_hit = 1'b0;
    stop_hit  = 1'b0;
    stop_lane = '0;
    prev_pc   = last_pc_q;
    prev_ok   = have_pc_q;
    for (int unsigned i = 0; i < NRET; i++) begin
      if (active[i]) begin
        n_act = n_act + NW'(1);
        if (lane_order[i] != exp_order_q + ORDER_W'(i)) begin
          order_err = 1'b1;
        end
        if (prev_ok && (lane_pc_r[i] != prev_pc)) begin
          pc_err = 1'b1;
        end
        prev_pc = lane_pc_w[i];
        prev_ok = 1'b1;
        if ((lane_pc_r[i] == lane_pc_w[i]) || (lane_inst[i] == INST_BEQ_SELF) ||
            (lane_inst[i] == INST_JAL_SELF) || (lane_inst[i] == INST_HALT_MARK)) begin
          halt_hit = 1'b1;
        end
        if (lane_inst[i] == INST_SEG_START) begin
          start_hit = 1'b1;
        end
        if ((lane_inst[i] == INST_SEG_STOP) && !stop_hit) begin
          stop_hit  = 1'b1;
          stop_lane = LW'(i);
        end
      end
    end
    for (int unsigned i = 1; i < NRET; i++) begin
      if (active[i] && !active[i-1]) begin
        gap_err = 1'b1;
      end
    end
  end

  assign timeout_err  = (n_act == '0) && (idle_q >= IW'(TIMEOUT - 1)) && !halt_q;
  assign posthalt_err = (n_act != '0) && halt_q;
  assign any_err      = gap_err | order_err | pc_err | timeout_err | posthalt_err;

  // Lowest code wins among errors raised in the same cycle
  always_comb begin
    new_code = ERR_NONE;
    if (gap_err)           new_code = ERR_GAP;
    else if (order_err)    new_code = ERR_ORDER;
    else if (pc_err)       new_code = ERR_PC;
    else if (timeout_err)  new_code = ERR_TIMEOUT;
    else if (posthalt_err) new_code = ERR_POSTHALT;
  end

  // Protocol tracking, error and halt next state
  always_comb begin
    halt_d      = halt_q | halt_hit;
    error_d     = error_q | any_err;
    err_code_d  = (!error_q && any_err) ? new_code : err_code_q;
    exp_order_d = gap_err ? exp_order_q : exp_order_q + ORDER_W'(n_act);
    have_pc_d   = have_pc_q | (n_act != '0);
    last_pc_d   = (n_act != '0) ? prev_pc : last_pc_q;
    idle_d      = idle_q;
    if (n_act != '0) begin
      idle_d = '0;
    end else if (idle_q != IW'(TIMEOUT)) begin
      idle_d = idle_q + IW'(1);
    end
  end

  // Segment FSM next state; a start marker overrides a stop in the same cycle
  always_comb begin
    seg_d      = seg_q;
    seg_done_d = 1'b0;
    inst_cnt_d = inst_cnt_q;
    cyc_cnt_d  = cyc_cnt_q;
    if (start_hit) begin
      seg_d      = SEG_RUN;
      inst_cnt_d = '0;
      cyc_cnt_d  = '0;
    end else begin
      case (seg_q)
        SEG_TOTAL: begin
          cyc_cnt_d  = sat_add(cyc_cnt_q, CNT_W'(1));
          inst_cnt_d = sat_add(inst_cnt_q, CNT_W'(n_act));
        end
        SEG_RUN: begin
          cyc_cnt_d = sat_add(cyc_cnt_q, CNT_W'(1));
          if (stop_hit) begin
            inst_cnt_d = sat_add(inst_cnt_q, CNT_W'(stop_lane) + CNT_W'(1));
            seg_d      = SEG_DONE;
            seg_done_d = 1'b1;
          end else begin
            inst_cnt_d = sat_add(inst_cnt_q, CNT_W'(n_act));
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      halt_q      <= 1'b0;
      error_q     <= 1'b0;
      err_code_q  <= ERR_NONE;
      seg_q       <= SEG_TOTAL;
      seg_done_q  <= 1'b0;
      inst_cnt_q  <= '0;
      cyc_cnt_q   <= '0;
      exp_order_q <= '0;
      have_pc_q   <= 1'b0;
      last_pc_q   <= '0;
      idle_q      <= '0;
    end else begin
      halt_q      <= halt_d;
      error_q     <= error_d;
      err_code_q  <= err_code_d;
      seg_q       <= seg_d;
      seg_done_q  <= seg_done_d;
      inst_cnt_q  <= inst_cnt_d;
      cyc_cnt_q   <= cyc_cnt_d;
      exp_order_q <= exp_order_d;
      have_pc_q   <= have_pc_d;
      last_pc_q   <= last_pc_d;
      idle_q      <= idle_d;
    end
  end

  assign halt_o        = halt_q;
  assign error_o       = error_q;
  assign err_code_o    = err_code_q;
  assign seg_state_o   = seg_q;
  assign seg_done_o    = seg_done_q;
  assign inst_count_o  = inst_cnt_q;
  assign cycle_count_o = cyc_cnt_q;

endmodule

// File: tb/tb_rvfi_multi_commit_monitor.sv
// Directed bench for rvfi_multi_commit_monitor (NRET=2, TIMEOUT=16) with an
// expectation queue filled at drive time and drained one cycle later.
module tb_rvfi_multi_commit_monitor;

  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] JAL   = 32'h0000_006f;
  localparam logic [31:0] BEQ   = 32'h0000_0063;
  localparam logic [31:0] START = 32'h0010_2013;
  localparam logic [31:0] STOP  = 32'h0020_2013;

  typedef struct packed {
    logic        halt;
    logic        error;
    logic [2:0]  code;
    logic [1:0]  seg;
    logic        done;
    logic [63:0] ic;
    logic [63:0] cc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        halt_o, error_o, seg_done_o;
  logic [2:0]  err_code_o;
  logic [1:0]  seg_state_o;
  logic [63:0] inst_count_o, cycle_count_o;

  int          checks   = 0;
  int          failures = 0;
  exp_t        sb[$];
  string       tagq[$];
  logic [63:0] ord;
  logic [31:0] pc;

  rvfi_multi_commit_monitor_if #(.NRET(2), .ORDER_W(64)) bus ();

  rvfi_multi_commit_monitor #(
    .NRET(2), .ORDER_W(64), .CNT_W(64), .TIMEOUT(16)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .rvfi_i        (bus),
    .halt_o        (halt_o),
    .error_o       (error_o),
    .err_code_o    (err_code_o),
    .seg_state_o   (seg_state_o),
    .seg_done_o    (seg_done_o),
    .inst_count_o  (inst_count_o),
    .cycle_count_o (cycle_count_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_lane(input int l, input logic [63:0] o, input logic [31:0] ins,
                          input logic [31:0] pr, input logic [31:0] pw);
    bus.order[l*64 +: 64]  = o;
    bus.inst[l*32 +: 32]   = ins;
    bus.pc_rdata[l*32 +: 32] = pr;
    bus.pc_wdata[l*32 +: 32] = pw;
  endtask

  // Well-formed commit on lane l continuing the bench's order/PC chain
  task automatic commit(input int l, input logic [31:0] ins);
    set_lane(l, ord, ins, pc, pc + 32'd4);
    ord = ord + 64'd1;
    pc  = pc + 32'd4;
  endtask

  // Queue the expectation for this cycle's inputs, clock once, then compare
  task automatic tick(input string tag, input logic h, input logic e, input logic [2:0] c,
                      input logic [1:0] s, input logic d, input logic [63:0] ic,
                      input logic [63:0] cc);
    exp_t x;
    x.halt = h; x.error = e; x.code = c; x.seg = s; x.done = d; x.ic = ic; x.cc = cc;
    sb.push_back(x);
    tagq.push_back(tag);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL %s observed=empty_queue expected=entry", tag);
    end else begin
      string t;
      x = sb.pop_front();
      t = tagq.pop_front();
      check({t, ".halt"},  64'(halt_o),        64'(x.halt));
      check({t, ".error"}, 64'(error_o),       64'(x.error));
      check({t, ".code"},  64'(err_code_o),    64'(x.code));
      check({t, ".seg"},   64'(seg_state_o),   64'(x.seg));
      check({t, ".done"},  64'(seg_done_o),    64'(x.done));
      check({t, ".inst"},  inst_count_o,       x.ic);
      check({t, ".cyc"},   cycle_count_o,      x.cc);
    end
  endtask

  // Reset with junk commits on the bus; they must be ignored
  task automatic do_reset(input string tag);
    rst = 1'b1;
    bus.valid = 2'b11;
    set_lane(0, 64'hdead, START, 32'h100, 32'h100);
    set_lane(1, 64'h7, JAL, 32'h200, 32'h200);
    tick(tag, 0, 0, 3'd0, 2'd0, 0, 64'd0, 64'd0);
    rst = 1'b0;
    bus.valid = 2'b00;
    ord = 64'd0;
    pc  = 32'h6000_0000;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    rst = 1'b1;
    bus.valid = 2'b00;
    bus.order = '0;
    bus.inst = '0;
    bus.pc_rdata = '0;
    bus.pc_wdata = '0;
    ord = 64'd0;
    pc  = 32'h6000_0000;

    // Clean dual retire: 12 instructions over 6 cycles
    do_reset("rst_basic");
    for (int k = 1; k <= 6; k++) begin
      bus.valid = 2'b11;
      commit(0, NOP);
      commit(1, NOP);
      tick("basic", 0, 0, 3'd0, 2'd0, 0, 64'(2*k), 64'(k));
    end

    // Lane 1 without lane 0
    do_reset("rst_gap");
    bus.valid = 2'b10;
    set_lane(1, 64'd1, NOP, pc, pc + 32'd4);
    tick("gap", 0, 1, 3'd1, 2'd0, 0, 64'd1, 64'd1);
    bus.valid = 2'b00;
    tick("gap_hold", 0, 1, 3'd1, 2'd0, 0, 64'd1, 64'd2);

    // Order skip on lane 1, later PC error must not overwrite the code
    do_reset("rst_order");
    bus.valid = 2'b11;
    commit(0, NOP);
    commit(1, NOP);
    tick("order_pre1", 0, 0, 3'd0, 2'd0, 0, 64'd2, 64'd1);
    bus.valid = 2'b01;
    commit(0, NOP);
    tick("order_pre2", 0, 0, 3'd0, 2'd0, 0, 64'd3, 64'd2);
    bus.valid = 2'b11;
    set_lane(0, 64'd3, NOP, pc, pc + 32'd4);
    set_lane(1, 64'd5, NOP, pc + 32'd4, pc + 32'd8);
    tick("order", 0, 1, 3'd2, 2'd0, 0, 64'd5, 64'd3);
    bus.valid = 2'b01;
    set_lane(0, 64'd5, NOP, 32'h6000_0020, 32'h6000_0024);
    tick("order_keep", 0, 1, 3'd2, 2'd0, 0, 64'd6, 64'd4);

    // PC break across cycles
    do_reset("rst_pc");
    bus.valid = 2'b11;
    commit(0, NOP);
    commit(1, NOP);
    tick("pc_pre1", 0, 0, 3'd0, 2'd0, 0, 64'd2, 64'd1);
    bus.valid = 2'b01;
    commit(0, NOP);
    tick("pc_pre2", 0, 0, 3'd0, 2'd0, 0, 64'd3, 64'd2);
    set_lane(0, 64'd3, NOP, 32'h6000_0010, 32'h6000_0014);
    tick("pc", 0, 1, 3'd3, 2'd0, 0, 64'd4, 64'd3);

    // PC break between lanes of the first commit cycle
    do_reset("rst_pc_lane");
    bus.valid = 2'b11;
    set_lane(0, 64'd0, NOP, 32'h6000_0000, 32'h6000_0004);
    set_lane(1, 64'd1, NOP, 32'h6000_0008, 32'h6000_000C);
    tick("pc_lane", 0, 1, 3'd3, 2'd0, 0, 64'd2, 64'd1);

    // Segment: start at cycle 10, stop in lane 0 at cycle 20
    do_reset("rst_seg");
    for (int k = 1; k <= 9; k++) begin
      tick("seg_pre", 0, 0, 3'd0, 2'd0, 0, 64'd0, 64'(k));
    end
    bus.valid = 2'b01;
    commit(0, START);
    tick("seg_start", 0, 0, 3'd0, 2'd1, 0, 64'd0, 64'd0);
    for (int j = 1; j <= 9; j++) begin
      bus.valid = 2'b11;
      commit(0, NOP);
      commit(1, NOP);
      tick("seg_run", 0, 0, 3'd0, 2'd1, 0, 64'(2*j), 64'(j));
    end
    commit(0, STOP);
    commit(1, NOP);
    tick("seg_stop", 0, 0, 3'd0, 2'd2, 1, 64'd19, 64'd10);
    commit(0, NOP);
    commit(1, NOP);
    tick("seg_frozen", 0, 0, 3'd0, 2'd2, 0, 64'd19, 64'd10);
    bus.valid = 2'b00;
    tick("seg_frozen_idle", 0, 0, 3'd0, 2'd2, 0, 64'd19, 64'd10);
    bus.valid = 2'b11;
    commit(0, STOP);
    commit(1, START);
    tick("seg_restart", 0, 0, 3'd0, 2'd1, 0, 64'd0, 64'd0);
    commit(0, NOP);
    commit(1, STOP);
    tick("seg_stop_l1", 0, 0, 3'd0, 2'd2, 1, 64'd2, 64'd1);
    bus.valid = 2'b01;
    commit(0, START);
    tick("seg_rearm", 0, 0, 3'd0, 2'd1, 0, 64'd0, 64'd0);
    bus.valid = 2'b00;

    // Halt by self-jump, then a commit after halt
    do_reset("rst_halt");
    bus.valid = 2'b01;
    commit(0, JAL);
    tick("halt", 1, 0, 3'd0, 2'd0, 0, 64'd1, 64'd1);
    commit(0, NOP);
    tick("posthalt", 1, 1, 3'd5, 2'd0, 0, 64'd2, 64'd2);

    // Halt by pc_rdata==pc_wdata; watchdog stays quiet while halted
    do_reset("rst_halt_pc");
    bus.valid = 2'b01;
    set_lane(0, 64'd0, NOP, pc, pc);
    tick("halt_pc", 1, 0, 3'd0, 2'd0, 0, 64'd1, 64'd1);
    bus.valid = 2'b00;
    for (int k = 2; k <= 21; k++) begin
      tick("halt_idle", 1, 0, 3'd0, 2'd0, 0, 64'd1, 64'(k));
    end

    // Watchdog: error exactly on the 16th idle cycle
    do_reset("rst_tmo");
    for (int k = 1; k <= 15; k++) begin
      tick("idle", 0, 0, 3'd0, 2'd0, 0, 64'd0, 64'(k));
    end
    tick("timeout", 0, 1, 3'd4, 2'd0, 0, 64'd0, 64'd16);

    // BEQ self-loop also halts
    do_reset("rst_beq");
    bus.valid = 2'b01;
    commit(0, BEQ);
    tick("halt_beq", 1, 0, 3'd0, 2'd0, 0, 64'd1, 64'd1);
    bus.valid = 2'b00;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rvfi_multi_commit_monitor.md
# rvfi_multi_commit_monitor

Parametrised, synthesizable successor to the single-retire RVFI bench monitor. It checks up to NRET commits per cycle for protocol consistency: lane contiguity, order sequence, PC chaining and commit-gap watchdog. It also detects halt and measures segment IPC counters in hardware. It sits beside the DUT's RVFI port in the Verilator bench; the bench reads its outputs to end simulation and report results.

## Interface
- NRET, 2: retire lanes per cycle (1..8).
- ORDER_W, 64: width of each lane's order field.
- CNT_W, 64: width of the inst/cycle counters.
- TIMEOUT, 100000: max cycles without any commit before a watchdog error.
- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- valid  in  NRET  per-lane commit valid.
- order  in  NRET*ORDER_W  lane i at [i*ORDER_W +: ORDER_W].
- inst  in  NRET*32  committed instruction per lane.
- pc_rdata  in  NRET*32  PC of the committed instruction.
- pc_wdata  in  NRET*32  next PC.
- halt  out  1  sticky halt detected.
- error  out  1  sticky error flag.
- err_code  out  3  code of the first error: 0 none, 1 GAP, 2 ORDER, 3 PC, 4 TIMEOUT, 5 POSTHALT.
- seg_state  out  2  0 TOTAL, 1 SEG, 2 DONE.
- seg_done  out  1  one-cycle pulse when a segment stops.
- inst_count  out  CNT_W  instructions counted in the current segment or total.
- cycle_count  out  CNT_W  cycles counted in the current segment or total.

## Operation
- A lane is active when valid[i]=1 and rst=0. Lanes are processed in ascending index order. n = number of active lanes.
- GAP: valid[i]=1 while valid[i-1]=0, for any i≥1.
- ORDER: exp_order resets to 0. Active lane i must carry exp_order+i. After each cycle with no GAP error, exp_order += n (wraps modulo 2^ORDER_W).
- PC: each active lane's pc_rdata must equal the previous commit's pc_wdata. The previous commit is lane i-1 in the same cycle, or last_pc from an earlier cycle. There is no check until the first commit after reset; a have_pc flag tracks this. last_pc updates to the pc_wdata of the highest active lane.
- TIMEOUT: idle_cnt resets to 0 on reset or on any cycle with n>0, and increments otherwise. Reaching TIMEOUT while halt=0 is an error. The counter saturates.
- Halt: any active lane with pc_rdata==pc_wdata, or inst equal to 0x00000063, 0x0000006f or 0xF0002013, sets halt. Halt is sticky until rst.
- POSTHALT: any active lane when halt is already 1.
- Errors: error is sticky. err_code latches only when error is 0. On simultaneous errors, the lowest code wins.
- Segment FSM:
  - TOTAL (from reset): cycle_count +1 every cycle; inst_count +n.
  - Start marker (inst 0x00102013 on an active lane), from TOTAL, SEG or DONE: both counters load 0, other lanes in that cycle are ignored, and the FSM goes to SEG. Start takes priority over a same-cycle stop.
  - In SEG: cycle_count +1 every cycle; inst_count += active lanes.
  - Stop marker (0x00202013) in SEG at lane s: inst_count += s+1, cycle_count +1, then the FSM goes to DONE and seg_done pulses. Lanes after s are not counted.
  - DONE: counters frozen until the next start.
  - A stop marker in TOTAL or DONE is ignored.
  - Counters saturate at all-ones.

## Timing
- All outputs are registered and reflect the inputs sampled at edge k after edge k (one-cycle latency).
- Reset values: halt 0, error 0, err_code 0, seg_state TOTAL, seg_done 0, inst_count 0, cycle_count 0. Internal: exp_order 0, have_pc 0, idle_cnt 0.
- An rst asserted mid-segment or mid-error returns every register to its reset value on that edge. Inputs in that cycle are ignored.
- Checks run on every cycle with n>0, including after an error. Later errors do not change err_code.
- seg_done is high for exactly one cycle per stop.

## Test plan
- NRET=2: 6 cycles with both lanes valid, orders 0..11, chained PCs starting at 0x60000000 step 4 -> error=0, inst_count=12, cycle_count=6.
- valid=2'b10 at any cycle -> next cycle error=1, err_code=1.
- Lane 1 order=5 while expected is 4 -> err_code=2. A later PC mismatch in the same test leaves err_code=2.
- Lane 0 pc_rdata=0x60000010 after last_pc=0x6000000C -> err_code=3.
- Start in lane 0 at cycle 10; 2 lanes/cycle for 9 cycles; stop in lane 0 at cycle 20 -> seg_done pulse, inst_count=19, cycle_count=10, seg_state=DONE, values frozen afterwards.
- Commit inst 0x0000006f -> halt=1 next cycle. A further commit -> err_code=5. With TIMEOUT=16 and no commits and halt=0 -> err_code=4 after 16 idle cycles.
